crc_check: RTL and testbench

//  Receive-side CRC checker; counterpart of the crc2 generator. Accepts a DATA_W-bit

---
 rtl/crc_check.sv | 164 ++++++++++++++++
 tb/tb_crc_check.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_check.sv
// Receive-side CRC checker: divides {payload, received CRC} by a runtime
// polynomial one bit per clock (MSB first) and reports the syndrome and a pass flag.
module crc_check #(
    parameter int DATA_W = 32,
    parameter int CRC_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CRC_W-1:0]  crc_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic [CRC_W:0]    poly,
    input  logic              poly_in_valid,
    output logic              poly_in_ready,
    output logic [CRC_W-1:0]  out,
    output logic              crc_ok,
    output logic              poly_err,
    output logic              outvalid,
    input  logic              outready
);

    localparam int CW_W  = DATA_W + CRC_W;
    localparam int CNT_W = $clog2(CW_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             data_cap_q, data_cap_d;
    logic             poly_cap_q, poly_cap_d;
    logic             data_rdy_q, data_rdy_d;
    logic             poly_rdy_q, poly_rdy_d;
    logic [CW_W-1:0]  cw_q, cw_d;
    logic [CRC_W:0]   poly_q, poly_d;
    logic [CRC_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CRC_W-1:0] out_q, out_d;
    logic             crc_ok_q, crc_ok_d;
    logic             poly_err_q, poly_err_d;
    logic             outvalid_q, outvalid_d;

    logic             data_fire;
    logic             poly_fire;
    logic             fb;
    logic [CRC_W-1:0] rem_next;

    // Readies are registered, so a fire can only happen while IDLE and uncaptured.
    assign data_fire = data_in_valid && data_rdy_q;
    assign poly_fire = poly_in_valid && poly_rdy_q;

    // One step of GF(2) long division: shift in the next codeword bit and
    // subtract the polynomial whenever the x^CRC_W term falls out.
    assign fb       = rem_q[CRC_W-1];
    assign rem_next = {rem_q[CRC_W-2:0], cw_q[CW_W-1]} ^ (fb ? poly_q[CRC_W-1:0] : '0);

    always_comb begin
        state_d    = state_q;
        data_cap_d = data_cap_q;
        poly_cap_d = poly_cap_q;
        cw_d       = cw_q;
        poly_d     = poly_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        crc_ok_d   = crc_ok_q;
        poly_err_d = poly_err_q;
        outvalid_d = outvalid_q;

        case (state_q)
            IDLE: begin
                if (data_fire) begin
                    data_cap_d = 1'b1;
                    cw_d       = {data_in, crc_in};
                end
                if (poly_fire) begin
                    poly_cap_d = 1'b1;
                    poly_d     = poly;
                end
                if (data_cap_d && poly_cap_d) begin
                    rem_d = '0;
                    cnt_d = '0;
                    if (poly_d[CRC_W]) begin
                        state_d = SHIFT;
                    end else begin
                        // Without the x^CRC_W term there is no valid divisor.
                        state_d    = DONE;
                        out_d      = '0;
                        crc_ok_d   = 1'b0;
                        poly_err_d = 1'b1;
                        outvalid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                rem_d = rem_next;
                cw_d  = cw_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CW_W - 1)) begin
                    state_d    = DONE;
                    out_d      = rem_next;
                    crc_ok_d   = (rem_next == '0);
                    poly_err_d = 1'b0;
                    outvalid_d = 1'b1;
                end
            end
            DONE: begin
                if (outready) begin
                    outvalid_d = 1'b0;
                    data_cap_d = 1'b0;
                    poly_cap_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        data_rdy_d = (state_d == IDLE) && !data_cap_d;
        poly_rdy_d = (state_d == IDLE) && !poly_cap_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            data_cap_q <= 1'b0;
            poly_cap_q <= 1'b0;
            data_rdy_q <= 1'b0;
            poly_rdy_q <= 1'b0;
            cw_q       <= '0;
            poly_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            crc_ok_q   <= 1'b0;
            poly_err_q <= 1'b0;
            outvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_cap_q <= data_cap_d;
            poly_cap_q <= poly_cap_d;
            data_rdy_q <= data_rdy_d;
            poly_rdy_q <= poly_rdy_d;
            cw_q       <= cw_d;
            poly_q     <= poly_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            crc_ok_q   <= crc_ok_d;
            poly_err_q <= poly_err_d;
            outvalid_q <= outvalid_d;
        end
    end

    assign data_in_ready = data_rdy_q;
    assign poly_in_ready = poly_rdy_q;
    assign out           = out_q;
    assign crc_ok        = crc_ok_q;
    assign poly_err      = poly_err_q;
    assign outvalid      = outvalid_q;

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check: hand-computed syndromes cross-checked against
// a long-division reference of the payload, plus handshake/latency/reset scenarios.
module tb_crc_check;

    logic        clk;
    logic        reset;
    logic [31:0] data_in;
    logic [4:0]  crc_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [5:0]  poly;
    logic        poly_in_valid;
    logic        poly_in_ready;
    logic [4:0]  out;
    logic        crc_ok;
    logic        poly_err;
    logic        outvalid;
    logic        outready;

    int checks;
    int failures;

    crc_check #(.DATA_W(32), .CRC_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .crc_in        (crc_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .poly          (poly),
        .poly_in_valid (poly_in_valid),
        .poly_in_ready (poly_in_ready),
        .out           (out),
        .crc_ok        (crc_ok),
        .poly_err      (poly_err),
        .outvalid      (outvalid),
        .outready      (outready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload * x^5 mod poly, by plain polynomial long division.
    function automatic logic [4:0] crc2(input logic [31:0] d, input logic [5:0] p);
        logic [36:0] v;
        logic [36:0] pw;
        v  = {d, 5'b00000};
        pw = {31'b0, p};
        for (int i = 36; i >= 5; i--) begin
            if (v[i]) v = v ^ (pw << (i - 5));
        end
        return v[4:0];
    endfunction

    // Offers poly immediately and data after dly edges; returns once both were taken.
    task automatic send(input logic [31:0] d, input logic [4:0] c, input logic [5:0] p,
                        input int dly, output bit ok);
        bit dp, pp, dfire, pfire;
        int k;
        dp = 0; pp = 0; k = 0;
        data_in = d; crc_in = c; poly = p;
        poly_in_valid = 1'b1;
        data_in_valid = (dly == 0);
        while (!(dp && pp) && k < 100) begin
            @(negedge clk);
            dfire = data_in_valid && data_in_ready;
            pfire = poly_in_valid && poly_in_ready;
            @(posedge clk);
            #1;
            if (dfire) begin dp = 1; data_in_valid = 1'b0; end
            if (pfire) begin pp = 1; poly_in_valid = 1'b0; end
            k++;
            if (!dp && k >= dly) data_in_valid = 1'b1;
        end
        data_in_valid = 1'b0;
        poly_in_valid = 1'b0;
        ok = dp && pp;
    endtask

    // Counts edges from the capture edge until outvalid; -1 on timeout.
    task automatic wait_result(output int lat, output bit rdy_seen);
        lat = -1;
        rdy_seen = 0;
        if (outvalid) lat = 0;
        for (int n = 1; n <= 80 && lat < 0; n++) begin
            if (data_in_ready || poly_in_ready) rdy_seen = 1;
            @(posedge clk);
            #1;
            if (outvalid) lat = n;
        end
    endtask

    task automatic consume();
        outready = 1'b1;
        @(posedge clk);
        #1;
        outready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if ({out, crc_ok, poly_err, outvalid} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 00000000", {out, crc_ok, poly_err, outvalid});
        end
        checks++;
        if ({data_in_ready, poly_in_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: got %b want 00", {data_in_ready, poly_in_ready});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({data_in_ready, poly_in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL ready_after_reset: got %b want 11", {data_in_ready, poly_in_ready});
        end
    endtask

    task automatic test_basic();
        logic [31:0] tdata [4];
        logic [4:0]  tcrc  [4];
        logic [4:0]  tout  [4];
        logic        tok   [4];
        bit ok, rdy_seen;
        int lat;
        tdata[0] = 32'h1; tcrc[0] = 5'b00101; tout[0] = 5'b00000; tok[0] = 1'b1;
        tdata[1] = 32'h1; tcrc[1] = 5'b00100; tout[1] = 5'b00001; tok[1] = 1'b0;
        tdata[2] = 32'h3; tcrc[2] = 5'b00101; tout[2] = 5'b01010; tok[2] = 1'b0;
        tdata[3] = 32'h3; tcrc[3] = 5'b01111; tout[3] = 5'b00000; tok[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(tdata[i], tcrc[i], 6'b100101, 0, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL basic%0d_capture: got timeout want handshake", i);
            end
            wait_result(lat, rdy_seen);
            checks++;
            if (lat !== 37) begin
                failures++;
                $display("FAIL basic%0d_latency: got %0d want 37", i, lat);
            end
            checks++;
            if (rdy_seen) begin
                failures++;
                $display("FAIL basic%0d_ready_in_shift: got 1 want 0", i);
            end
            checks++;
            if (out !== tout[i]) begin
                failures++;
                $display("FAIL basic%0d_out: got %b want %b", i, out, tout[i]);
            end
            checks++;
            if (out !== (crc2(tdata[i], 6'b100101) ^ tcrc[i])) begin
                failures++;
                $display("FAIL basic%0d_ref: got %b want %b", i, out, crc2(tdata[i], 6'b100101) ^ tcrc[i]);
            end
            checks++;
            if ({crc_ok, poly_err} !== {tok[i], 1'b0}) begin
                failures++;
                $display("FAIL basic%0d_flags: got %b want %b", i, {crc_ok, poly_err}, {tok[i], 1'b0});
            end
            consume();
            checks++;
            if (outvalid !== 1'b0 || out !== tout[i]) begin
                failures++;
                $display("FAIL basic%0d_after_accept: got v=%b out=%b want v=0 out=%b", i, outvalid, out, tout[i]);
            end
            checks++;
            if ({data_in_ready, poly_in_ready} !== 2'b11) begin
                failures++;
                $display("FAIL basic%0d_ready_back: got %b want 11", i, {data_in_ready, poly_in_ready});
            end
        end
    endtask

    task automatic test_ordering();
        bit ok, rdy_seen;
        int lat;
        send(32'h3, 5'b00101, 6'b100101, 3, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL order_capture: got timeout want handshake");
        end
        wait_result(lat, rdy_seen);
        checks++;
        if (lat !== 37) begin
            failures++;
            $display("FAIL order_latency: got %0d want 37", lat);
        end
        checks++;
        if (out !== 5'b01010 || crc_ok !== 1'b0) begin
            failures++;
            $display("FAIL order_result: got out=%b ok=%b want out=01010 ok=0", out, crc_ok);
        end
        consume();
    endtask

    task automatic test_hold();
        bit ok, rdy_seen, moved;
        int lat;
        send(32'h1, 5'b00101, 6'b100101, 0, ok);
        wait_result(lat, rdy_seen);
        checks++;
        if (lat !== 37 || out !== 5'b00000 || crc_ok !== 1'b1) begin
            failures++;
            $display("FAIL hold_result: got lat=%0d out=%b ok=%b want lat=37 out=00000 ok=1", lat, out, crc_ok);
        end
        moved = 0;
        data_in = 32'hDEADBEEF; crc_in = 5'b11111; poly = 6'b110001;
        data_in_valid = 1'b1; poly_in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (outvalid !== 1'b1 || out !== 5'b00000 || crc_ok !== 1'b1 || poly_err !== 1'b0
                || data_in_ready !== 1'b0 || poly_in_ready !== 1'b0) moved = 1;
        end
        data_in_valid = 1'b0; poly_in_valid = 1'b0;
        checks++;
        if (moved) begin
            failures++;
            $display("FAIL hold_stable: got change while outready=0 want stable");
        end
        consume();
        checks++;
        if ({outvalid, data_in_ready, poly_in_ready} !== 3'b011) begin
            failures++;
            $display("FAIL hold_release: got %b want 011", {outvalid, data_in_ready, poly_in_ready});
        end
    endtask

    task automatic test_poly_err();
        bit ok, rdy_seen;
        int lat;
        send(32'h1, 5'b00101, 6'b000101, 0, ok);
        wait_result(lat, rdy_seen);
        checks++;
        if (lat !== 0) begin
            failures++;
            $display("FAIL perr_latency: got %0d want 0", lat);
        end
        checks++;
        if ({out, crc_ok, poly_err, outvalid} !== {5'b00000, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL perr_outputs: got %b want 00000011", {out, crc_ok, poly_err, outvalid});
        end
        consume();
        checks++;
        if ({poly_err, outvalid} !== 2'b10) begin
            failures++;
            $display("FAIL perr_held: got %b want 10", {poly_err, outvalid});
        end
    endtask

    task automatic test_reset_mid();
        bit ok, rdy_seen;
        int lat;
        send(32'h3, 5'b00100, 6'b100101, 0, ok);
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({out, crc_ok, poly_err, outvalid, data_in_ready, poly_in_ready} !== 10'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got %b want 0000000000",
                     {out, crc_ok, poly_err, outvalid, data_in_ready, poly_in_ready});
        end
        @(negedge clk);
        reset = 1'b1;
        send(32'h1, 5'b00101, 6'b100101, 0, ok);
        wait_result(lat, rdy_seen);
        checks++;
        if (lat !== 37 || out !== 5'b00000 || crc_ok !== 1'b1) begin
            failures++;
            $display("FAIL midreset_rerun: got lat=%0d out=%b ok=%b want lat=37 out=00000 ok=1", lat, out, crc_ok);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        bit ok, rdy_seen;
        int lat;
        send(32'h1, 5'b00100, 6'b100101, 0, ok);
        wait_result(lat, rdy_seen);
        checks++;
        if (lat !== 37 || out !== 5'b00001 || crc_ok !== 1'b0 || poly_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d out=%b ok=%b perr=%b want lat=37 out=00001 ok=0 perr=0",
                     lat, out, crc_ok, poly_err);
        end
        consume();
        send(32'h3, 5'b01111, 6'b100101, 0, ok);
        wait_result(lat, rdy_seen);
        checks++;
        if (lat !== 37 || out !== (crc2(32'h3, 6'b100101) ^ 5'b01111) || crc_ok !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d out=%b ok=%b want lat=37 out=00000 ok=1", lat, out, crc_ok);
        end
        consume();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        data_in = '0; crc_in = '0; poly = '0;
        data_in_valid = 1'b0; poly_in_valid = 1'b0; outready = 1'b0;
        test_reset();
        test_basic();
        test_ordering();
        test_hold();
        test_poly_err();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
